// File: rtl/mul_operand_feeder.sv
// Operand sequencer for the serial shift-add multiplier core.
// Queues operand pairs, runs one multiply at a time, returns products in order.
module mul_operand_feeder #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           a_i,
    input  logic [WIDTH-1:0]           b_i,
    output logic [WIDTH-1:0]           core_a_o,
    output logic [WIDTH-1:0]           core_b_o,
    output logic                       core_start_o,
    input  logic                       core_done_i,
    input  logic [2*WIDTH-1:0]         core_y_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [2*WIDTH-1:0]         out_y_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [TW-1:0]    wait_cnt;
    state_t           state;

    logic push;
    logic pop;
    logic timed_out;

    // A full FIFO refuses input even if the FSM pops on the same edge.
    assign in_ready_o = (count != CW'(DEPTH));
    assign count_o    = count;
    assign push       = in_valid_i & in_ready_o;
    assign pop        = (state == IDLE) && (count != '0);
    assign timed_out  = (wait_cnt == TW'(TIMEOUT - 1));

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a[wr_ptr] <= a_i;
            mem_b[wr_ptr] <= b_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            core_a_o     <= '0;
            core_b_o     <= '0;
            core_start_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_y_o      <= '0;
            err_o        <= 1'b0;
        end else begin
            core_start_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        core_a_o     <= mem_a[rd_ptr];
                        core_b_o     <= mem_b[rd_ptr];
                        core_start_o <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (core_done_i) begin
                        out_y_o     <= core_y_i;
                        out_valid_o <= 1'b1;
                        state       <= HOLD;
                    end else if (timed_out) begin
                        err_o       <= 1'b1;
                        out_y_o     <= '0;
                        out_valid_o <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Bench for mul_operand_feeder: directed vectors, corner sequences,
// and randomized traffic against a queue-based product model.
module tb_mul_operand_feeder;

    localparam int W = 16;
    localparam int D = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  core_a;
    logic [W-1:0]  core_b;
    logic          core_start;
    logic          core_done;
    logic [2*W-1:0] core_y;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_y;
    logic [$clog2(D):0] count;
    logic          err;

    mul_operand_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(40)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .a_i(a),
        .b_i(b),
        .core_a_o(core_a),
        .core_b_o(core_b),
        .core_start_o(core_start),
        .core_done_i(core_done),
        .core_y_i(core_y),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_y_o(out_y),
        .count_o(count),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Core model: done pulse sampled L edges after the ISSUE cycle ends.
    int   core_lat = 17;
    bit   core_hang = 0;
    bit   core_rand = 0;
    int   core_left = 0;
    bit   core_busy = 0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;

    initial begin
        core_done = 1'b0;
        core_y = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            core_busy = 0;
            core_done = 1'b0;
            core_left = 0;
        end else begin
            core_done = 1'b0;
            if (core_busy) begin
                core_left--;
                if (core_left <= 0) begin
                    core_done = 1'b1;
                    core_y = 32'(cap_a) * 32'(cap_b);
                    core_busy = 0;
                end
            end
            if (core_start && !core_hang) begin
                core_busy = 1;
                core_left = core_rand ? int'($urandom_range(1, 30)) : core_lat;
                cap_a = core_a;
                cap_b = core_b;
            end
        end
    end

    // Reference: every accepted pair must come back, in order, as a*b.
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    bit sb_en = 1;
    int start_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) start_cnt++;
            if (sb_en) begin
                if (in_valid && in_ready) exp_q.push_back(32'(a) * 32'(b));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra_result", 1, 0);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        check("sb_result", out_y, sb_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb);
        in_valid = 1'b1;
        a = pa;
        b = pb;
        step();
        in_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            step();
            n++;
        end
        if (!out_valid) check("wait_valid_bound", 0, 1);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid || count != 0) && n < limit) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check("drain_empty", exp_q.size(), 0);
        check("drain_count", count, 0);
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             lat;
        logic [2*W-1:0] y;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        bit stable;
        bit seen;
        logic [2*W-1:0] y0;

        vecs[0] = '{a: 16'd3,      b: 16'd5,      lat: 17, y: 32'h0000_000F};
        vecs[1] = '{a: 16'hFFFF,   b: 16'hFFFF,   lat: 17, y: 32'hFFFE_0001};
        vecs[2] = '{a: 16'h0000,   b: 16'h1234,   lat: 17, y: 32'h0000_0000};
        vecs[3] = '{a: 16'h8000,   b: 16'h0002,   lat: 5,  y: 32'h0001_0000};
        vecs[4] = '{a: 16'h1234,   b: 16'h5678,   lat: 1,  y: 32'h0626_0060};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_start", core_start, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_out_y", out_y, 0);
        check("rst_core_a", core_a, 0);
        rst = 1'b0;
        step();

        // Single op with exact pulse and latency timing
        core_lat = 17;
        s0 = start_cnt;
        push(16'd3, 16'd5);
        check("single_count1", count, 1);
        check("single_start_early", core_start, 0);
        step();
        check("single_start", core_start, 1);
        check("single_count0", count, 0);
        check("single_core_a", core_a, 3);
        check("single_core_b", core_b, 5);
        step();
        check("single_start_drop", core_start, 0);
        wait_valid(100, n);
        check("single_latency", n, 17);
        check("single_y", out_y, 32'h0000_000F);
        check("single_pulses", start_cnt - s0, 1);
        accept();
        check("single_valid_drop", out_valid, 0);

        for (int i = 0; i < 5; i++) begin
            core_lat = vecs[i].lat;
            s0 = start_cnt;
            push(vecs[i].a, vecs[i].b);
            wait_valid(100, n);
            check("vec_latency", n, vecs[i].lat + 2);
            check("vec_y", out_y, vecs[i].y);
            check("vec_count", count, 0);
            check("vec_pulses", start_cnt - s0, 1);
            accept();
            check("vec_valid_drop", out_valid, 0);
            step();
        end

        // Full FIFO: one op in flight, then five back-to-back pairs
        core_lat = 30;
        push(16'd1, 16'd1);
        step();
        step();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            a = 16'(i + 1);
            b = 16'(i + 2);
            check("full_ready", in_ready, (i <= 4) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        check("full_count", count, 4);
        check("full_ready_low", in_ready, 0);
        wait_valid(100, n);
        check("full_count_hold", count, 4);
        in_valid = 1'b1;
        a = 16'd9;
        b = 16'd9;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_ready_after_hs", in_ready, 0);
        step();
        in_valid = 1'b0;
        check("full_pop_ignores_push", count, 3);
        check("full_ready_back", in_ready, 1);
        drain(1000);

        // Back-pressure with two queued pairs
        core_lat = 17;
        push(16'd2, 16'd2);
        push(16'd7, 16'd9);
        wait_valid(100, n);
        y0 = out_y;
        s0 = start_cnt;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_y !== y0 || out_valid !== 1'b1) stable = 0;
        end
        check("bp_stable", stable, 1);
        check("bp_no_start", start_cnt - s0, 0);
        check("bp_first_y", out_y, 4);
        check("bp_count", count, 1);
        accept();
        wait_valid(100, n);
        check("bp_second_y", out_y, 63);
        accept();
        step();

        // Timeout: core hangs on the first pair only
        sb_en = 0;
        exp_q.delete();
        core_hang = 1;
        push(16'd6, 16'd7);
        push(16'd11, 16'd13);
        check("to_err_before", err, 0);
        wait_valid(200, n);
        check("to_latency", n, 41);
        check("to_err", err, 1);
        check("to_valid", out_valid, 1);
        check("to_y_zero", out_y, 0);
        core_hang = 0;
        s0 = start_cnt;
        accept();
        wait_valid(100, n);
        check("to_next_issued", start_cnt - s0, 1);
        check("to_next_y", out_y, 143);
        check("to_err_sticky", err, 1);
        accept();
        step();

        // Asynchronous reset mid-WAIT with three pairs queued
        core_lat = 17;
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        push(16'd7, 16'd8);
        step();
        step();
        step();
        check("rw_pre_count", count, 3);
        #2;
        rst = 1'b1;
        #1;
        check("rw_valid", out_valid, 0);
        check("rw_start", core_start, 0);
        check("rw_count", count, 0);
        check("rw_ready", in_ready, 1);
        check("rw_err", err, 0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid || core_start) seen = 1;
        end
        check("rw_no_stale", seen, 0);

        // Randomized traffic against the ordered product model
        exp_q.delete();
        sb_en = 1;
        core_rand = 1;
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_ready_rule", in_ready, (count != 4) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        drain(3000);
        check("rnd_err", err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
